// File: rtl/timer_pkg.sv
// Shared types, limits and BCD helpers for the two-digit countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  typedef logic [3:0] bcd_t;
  typedef logic [6:0] bin_t;

  localparam bcd_t BCD_MAX   = 4'd9;
  localparam int   TIMER_MAX = 99;

  function automatic bcd_t bcd_clamp(input bcd_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  function automatic bin_t bcd_to_bin(input bcd_t t, input bcd_t o);
    return bin_t'(t) * 7'd10 + bin_t'(o);
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit decrementer; chain borrow_out into the next digit's borrow_in.
module bcd_digit_dec
  import timer_pkg::*;
(
  input  logic [3:0] digit_in,
  input  logic       borrow_in,
  output logic [3:0] digit_out,
  output logic       borrow_out
);

  always_comb begin
    digit_out  = digit_in;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit_in == 4'd0) begin
        digit_out  = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        digit_out = digit_in - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer with start/pause/load control and expiry events.
// Define TIMER_BONUS_EN to add the `bonus` input that adds BONUS_VALUE seconds.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int WARN_THRESHOLD = 10
`ifdef TIMER_BONUS_EN
  , parameter int BONUS_VALUE = 5
`endif
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       tick,
  input  logic       loadN,
  input  logic [3:0] init_tens,
  input  logic [3:0] init_ones,
  input  logic       start,
  input  logic       pause,
`ifdef TIMER_BONUS_EN
  input  logic       bonus,
`endif
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       expired,
  output logic       time_up,
  output logic       warning
);

  localparam bin_t WARN_BIN = bin_t'(WARN_THRESHOLD);

  state_t state_q, state_d;
  bcd_t   tens_q, tens_d, ones_q, ones_d;
  bcd_t   init_tens_q, init_tens_d, init_ones_q, init_ones_d;
  logic   time_up_q, time_up_d;
  logic   warning_q, warning_d;

  logic   dec_en, ones_borrow, underflow, value_zero;
  bcd_t   dec_tens, dec_ones;

  assign value_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
  // Start is ignored in RUN, so only load and pause can block a tick here.
  assign dec_en     = (state_q == RUN) && loadN && !pause && tick;

  bcd_digit_dec u_ones_dec (
    .digit_in   (ones_q),
    .borrow_in  (dec_en),
    .digit_out  (dec_ones),
    .borrow_out (ones_borrow)
  );

  bcd_digit_dec u_tens_dec (
    .digit_in   (tens_q),
    .borrow_in  (ones_borrow),
    .digit_out  (dec_tens),
    .borrow_out (underflow)
  );

`ifdef TIMER_BONUS_EN
  localparam bin_t BONUS_BIN = bin_t'(BONUS_VALUE);

  logic       bonus_en;
  logic [7:0] bonus_sum;
  bin_t       bonus_sat;

  assign bonus_en = bonus && loadN && ((state_q == RUN) || (state_q == PAUSE));

  // dec_en implies a non-zero value, so the subtraction cannot go negative.
  always_comb begin
    bonus_sum = {1'b0, bcd_to_bin(tens_q, ones_q)} + {1'b0, BONUS_BIN} - {7'd0, dec_en};
    bonus_sat = (bonus_sum > 8'(TIMER_MAX)) ? bin_t'(TIMER_MAX) : bonus_sum[6:0];
  end
`endif

  // NOTE: every flop updates with <= so all of them sample pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      tens_q      <= '0;
      ones_q      <= '0;
      init_tens_q <= '0;
      init_ones_q <= '0;
      time_up_q   <= 1'b0;
      warning_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      init_tens_q <= init_tens_d;
      init_ones_q <= init_ones_d;
      time_up_q   <= time_up_d;
      warning_q   <= warning_d;
    end
  end

  // NOTE: defaults up front keep every path assigned, so no latches appear.
  always_comb begin
    state_d     = state_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    init_tens_d = init_tens_q;
    init_ones_d = init_ones_q;
    time_up_d   = 1'b0;

    if (!loadN) begin
      init_tens_d = bcd_clamp(init_tens);
      init_ones_d = bcd_clamp(init_ones);
      tens_d      = bcd_clamp(init_tens);
      ones_d      = bcd_clamp(init_ones);
      state_d     = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          state_d   = value_zero ? DONE : RUN;
          time_up_d = value_zero;
        end
        RUN: if (pause) begin
          state_d = PAUSE;
        end else if (tick) begin
          tens_d = underflow ? 4'd0 : dec_tens;
          ones_d = underflow ? 4'd0 : dec_ones;
          if (underflow || (dec_tens == 4'd0 && dec_ones == 4'd0)) begin
            state_d   = DONE;
            time_up_d = 1'b1;
          end
        end
        PAUSE: if (!pause) state_d = RUN;
        DONE: if (start) begin
          tens_d = init_tens_q;
          ones_d = init_ones_q;
          if (init_tens_q == 4'd0 && init_ones_q == 4'd0) time_up_d = 1'b1;
          else state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end

`ifdef TIMER_BONUS_EN
    if (bonus_en) begin
      tens_d = bcd_t'(bonus_sat / 7'd10);
      ones_d = bcd_t'(bonus_sat % 7'd10);
      if (bonus_sat != '0 && state_d == DONE) begin
        state_d   = RUN;
        time_up_d = 1'b0;
      end
    end
`endif

    warning_d = ((state_d == RUN) || (state_d == PAUSE)) &&
                (bcd_to_bin(tens_d, ones_d) <= WARN_BIN) &&
                !(tens_d == 4'd0 && ones_d == 4'd0);
  end

  always_comb begin
    running = (state_q == RUN);
    expired = (state_q == DONE);
    tens    = tens_q;
    ones    = ones_q;
    time_up = time_up_q;
    warning = warning_q;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Two-digit BCD countdown timer (00..99) that consumes the one-cycle `tick` strobe produced by the periodic up-counter.
- Decrements once per accepted tick.
- Provides start, pause and load control.
- Drives digit values to the score/HUD display and raises a one-cycle `time_up` event plus an `expired` level for the game FSM.

Parameters:
- WARN_THRESHOLD, 10, `warning` asserts while RUN and value <= this (decimal, 0..99)
- BONUS_VALUE, 5, decimal seconds added per `bonus` pulse (only with TIMER_BONUS_EN)

Ports:
- clk  input  1  system clock
- resetN  input  1  asynchronous active-low reset
- tick  input  1  one-cycle strobe from up-counter; one decrement per high cycle
- loadN  input  1  synchronous active-low load of `init_tens`/`init_ones`
- init_tens  input  4  BCD tens for load
- init_ones  input  4  BCD ones for load
- start  input  1  one-cycle request to begin counting
- pause  input  1  level; high holds count
- tens  output  4  current BCD tens digit
- ones  output  4  current BCD ones digit
- running  output  1  high in RUN state
- expired  output  1  high in DONE state
- time_up  output  1  one-cycle pulse on reaching 00
- warning  output  1  low-time indicator

Behaviour:
- Reset (async, resetN=0):
  - state=IDLE; tens=ones=0; stored init=00.
  - running=expired=time_up=warning=0.
  - Reset mid-count aborts immediately; no `time_up` is produced.
- All other updates occur on posedge clk. Input priority per cycle: loadN > start > pause > tick.
- loadN=0:
  - Stores init and copies it into tens/ones; state becomes IDLE, in any state.
  - Any digit >9 is clamped to 9.
  - start/tick in the same cycle are ignored.
- States:
  - IDLE: start -> RUN. If the value is 00 at start, go to DONE instead with `time_up` pulse.
  - RUN:
    - pause=1 -> PAUSE; a tick in that cycle is ignored.
    - Else tick=1 decrements. If ones=0, then ones=9 and tens decrements, else ones decrements.
    - If the result is 00, go to DONE and pulse `time_up`.
  - PAUSE: pause=0 -> RUN. Ticks are ignored; that is, they are lost, not queued.
  - DONE: value holds 00. start reloads the stored init and goes to RUN. If the stored init is 00, pulse `time_up` again and stay in DONE.
- start is ignored in RUN and PAUSE.
- Latency:
  - Digits change in the cycle after the tick edge, i.e. they are registered.
  - `time_up` is registered and asserted in the same cycle the digits first show 00.
  - Exactly one `time_up` per expiry.
- No wrap-around: the value never goes below 00; ticks in DONE and IDLE have no effect.
- `warning`: registered; =1 when state is RUN or PAUSE and value <= WARN_THRESHOLD and value != 00.
- `running`/`expired` are decoded from the state register; they are not glitching combinational paths of the inputs.

Optional Feature:
- Macro TIMER_BONUS_EN.
- Defined:
  - Adds input `bonus` (1 bit, one-cycle pulse). In RUN or PAUSE it adds BONUS_VALUE in BCD, saturating at 99.
  - Same-cycle tick and bonus: result = value - 1 + BONUS_VALUE, saturated at 99.
  - Expiry is suppressed if the net result is >00.
  - Ignored in IDLE and DONE, and when loadN=0.
- Undefined: no `bonus` port and no adder logic; behaviour is exactly as above.

Decomposition:
- Package `timer_pkg`:
  - state enum {IDLE, RUN, PAUSE, DONE}
  - typedef bcd_t (logic [3:0])
  - constants BCD_MAX=4'd9 and TIMER_MAX=99
- Sub-module `bcd_digit_dec`: single BCD digit decrement with borrow-in/borrow-out, instantiated twice (ones feeds tens).
- Bonus add is inline, under the macro.

Test Plan:
- Reset during RUN at 37 -> all outputs 0 immediately (async), no `time_up`; after release, state is IDLE.
- loadN=0 with init 2/5, start, 25 ticks -> digits go 25,24,...,10,09,...,01,00. `time_up` is high for exactly one cycle when 00 appears, `expired`=1, and a 26th tick changes nothing.
- Load 1/0, start, tick -> 09 (borrow across digits). With WARN_THRESHOLD=10, `warning` is 1 at 10 and 09 and 0 at 00.
- In RUN at 15: raise pause together with a tick -> holds 15. 3 ticks in PAUSE -> still 15. Drop pause, 1 tick -> 14.
- Load 0/0, start -> DONE with one `time_up` pulse. Load 12 via init 1/12 -> clamped to 19.
- TIMER_BONUS_EN, value 97, bonus -> 99 (saturated). Value 01 with tick+bonus same cycle -> 05, no `time_up`.
